// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_MUL = 3'b110,
        OP_ACC = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit positions inside the {Z,N,C,V} flags vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier taking exactly WIDTH iterations.
// The first iteration happens on the start edge itself, so done rises
// WIDTH-1 edges after start and the product is valid while done is high.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               active_q, active_d;

    assign done    = active_q && (count_q == LAST);
    assign product = prod_q;

    // Next-state for the shift-add datapath: load plus first iteration on start, then one iteration per enabled cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        count_d  = count_q;
        active_d = active_q;
        if (en) begin
            if (start) begin
                mcand_d  = {{WIDTH{1'b0}}, a} << 1;
                mplier_d = b >> 1;
                prod_d   = b[0] ? {{WIDTH{1'b0}}, a} : '0;
                count_d  = CNT_W'(1);
                active_d = 1'b1;
            end else if (active_q) begin
                if (done) begin
                    active_d = 1'b0;
                    count_d  = '0;
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CNT_W'(1);
                end
            end
        end
    end

    // Multiplier registers; reset aborts any multiply in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake, multi-cycle multiply and a 2*WIDTH accumulator.
// A new request may be taken while idle or while the pending result is being drained.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [3:0]         flags,
    output logic               busy
);

    localparam int SH_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    opcode_e            op;
    logic               accept;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH:0]     shl_full;
    logic [2*WIDTH-1:0] acc_base;
    logic [2*WIDTH:0]   acc_full;
    logic [2*WIDTH-1:0] alu_res;
    logic [3:0]         alu_flags;

    assign op        = opcode_e'(opcode);
    assign in_ready  = en && (state_q != ST_MUL) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};
    assign shl_full = {1'b0, a} << b[SH_W-1:0];
    assign acc_base = acc_clr ? '0 : acc_q;
    assign acc_full = {1'b0, acc_base} + {{(WIDTH+1){1'b0}}, a};

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .start   (accept && (op == OP_MUL)),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle result and flags for every opcode except MUL.
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (op)
            OP_ADD: begin
                alu_res           = {{(WIDTH-1){1'b0}}, add_full};
                alu_flags[FLAG_C] = add_full[WIDTH];
                alu_flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res           = {{WIDTH{1'b0}}, sub_full[WIDTH-1:0]};
                alu_flags[FLAG_C] = sub_full[WIDTH];
                alu_flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = {{WIDTH{1'b0}}, a & b};
            OP_OR:  alu_res = {{WIDTH{1'b0}}, a | b};
            OP_XOR: alu_res = {{WIDTH{1'b0}}, a ^ b};
            OP_SHL: begin
                alu_res           = {{WIDTH{1'b0}}, shl_full[WIDTH-1:0]};
                alu_flags[FLAG_C] = shl_full[WIDTH];
            end
            OP_ACC: begin
                alu_res           = acc_full[2*WIDTH-1:0];
                alu_flags[FLAG_C] = acc_full[2*WIDTH];
            end
            default: alu_res = '0;
        endcase
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = (op == OP_ACC) ? alu_res[2*WIDTH-1] : alu_res[WIDTH-1];
    end

    // FSM next-state, output registers and accumulator; everything holds while en is low.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        if (en) begin
            if (acc_clr) begin
                acc_d = '0;
            end
            if (accept) begin
                if (op == OP_MUL) begin
                    state_d     = ST_MUL;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    flags_d     = alu_flags;
                    if (op == OP_ACC) begin
                        acc_d = acc_full[2*WIDTH-1:0];
                    end
                end
            end else begin
                case (state_q)
                    ST_MUL: begin
                        if (mul_done) begin
                            state_d           = ST_DONE;
                            out_valid_d       = 1'b1;
                            result_d          = mul_product;
                            flags_d           = '0;
                            flags_d[FLAG_Z]   = (mul_product == '0);
                            flags_d[FLAG_N]   = mul_product[2*WIDTH-1];
                        end
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            state_d     = ST_IDLE;
                            out_valid_d = 1'b0;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 with an arithmetic reference model.
module tb_alu_seq;

    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int modelAcc = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: returns {Z,N,C,V,result[15:0]} from plain integer arithmetic.
    function automatic logic [19:0] refModel(input int op, input int ia, input int ib, input int accIn, output int accOut);
        int r, s, sa, sb, sh;
        logic z, n, c, v;
        logic [15:0] r16;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        accOut = accIn;
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        case (op)
            0: begin r = ia + ib; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            1: begin r = (ia - ib) & 255; c = (ia < ib); s = sa - sb; v = (s > 127) || (s < -128); end
            2: r = ia & ib;
            3: r = ia | ib;
            4: r = ia ^ ib;
            5: begin
                sh = ib % 8;
                r = (ia << sh) & 255;
                c = (sh > 0) ? (((ia >> (8 - sh)) & 1) == 1) : 1'b0;
            end
            6: r = ia * ib;
            default: begin
                s = accIn + ia;
                c = (s > 65535);
                r = s % 65536;
                accOut = r;
            end
        endcase
        r16 = r[15:0];
        z = (r16 == 16'h0);
        n = (op >= 6) ? r16[15] : r16[7];
        return {z, n, c, v, r16};
    endfunction

    // Issue one request, wait (bounded) for its result and compare with the model.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib, input logic clr, input string tag);
        logic [19:0] expv;
        int accNext;
        int lat;
        int expLat;
        expv = refModel(int'(op), int'(ia), int'(ib), clr ? 0 : modelAcc, accNext);
        opcode    = op;
        a         = ia;
        b         = ib;
        acc_clr   = clr;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        if (clr) modelAcc = 0;
        if (op == 3'd7) modelAcc = accNext;
        expLat = (op == 3'd6) ? 9 : 1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            step();
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_result"}, 32'(result), 32'(expv[15:0]));
        checkOutput({tag, "_flags"}, 32'(flags), 32'(expv[19:16]));
    endtask

    initial begin
        logic [19:0] expv;
        logic [15:0] heldRes;
        logic [3:0]  heldFlags;
        int dummy;
        int lat;

        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; acc_clr = 1'b0;
        out_ready = 1'b1; opcode = 3'd0; a = 8'd0; b = 8'd0;
        #12;
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_flags", 32'(flags), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases, first one on the first edge after reset release.
        applyStimulus(3'd0, 8'hF0, 8'h20, 1'b0, "add_carry");
        checkOutput("add_carry_const", 32'(result), 32'h0110);
        checkOutput("add_carry_flags_const", 32'(flags), 32'b0010);
        applyStimulus(3'd1, 8'h10, 8'h20, 1'b0, "sub_borrow");
        checkOutput("sub_borrow_flags_const", 32'(flags), 32'b0110);
        applyStimulus(3'd1, 8'h7F, 8'hFF, 1'b0, "sub_ovf");
        checkOutput("sub_ovf_v", 32'(flags[0]), 32'd1);
        applyStimulus(3'd6, 8'hFF, 8'hFF, 1'b0, "mul_ff");
        checkOutput("mul_ff_const", 32'(result), 32'hFE01);
        checkOutput("mul_ff_flags_const", 32'(flags), 32'b0100);
        applyStimulus(3'd5, 8'hC3, 8'h03, 1'b0, "shl3");

        // Stall the consumer: result frozen, requests ignored, then back-to-back accept.
        applyStimulus(3'd0, 8'h35, 8'h4A, 1'b0, "hold_add");
        heldRes = result;
        heldFlags = flags;
        out_ready = 1'b0;
        opcode = 3'd1; a = 8'h01; b = 8'h01; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_result", 32'(result), 32'h007F);
            checkOutput("hold_flags", 32'(flags), 32'(heldFlags));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        checkOutput("hold_result_model", 32'(heldRes), 32'h007F);
        opcode = 3'd4; a = 8'h5A; b = 8'h0F; out_ready = 1'b1;
        #1;
        checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        expv = refModel(4, 8'h5A, 8'h0F, modelAcc, dummy);
        checkOutput("b2b_out_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_result", 32'(result), 32'(expv[15:0]));

        // Accumulator: lone clear must not disturb a pending result, then wrap after 258 adds.
        applyStimulus(3'd7, 8'h33, 8'h00, 1'b1, "acc_seed");
        out_ready = 1'b0;
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        modelAcc = 0;
        checkOutput("clr_out_valid", 32'(out_valid), 32'd1);
        checkOutput("clr_result", 32'(result), 32'h0033);
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 258; i++) begin
            applyStimulus(3'd7, 8'hFF, 8'h00, 1'b0, "acc_ff");
        end
        checkOutput("acc_wrap_result", 32'(result), 32'h00FE);
        checkOutput("acc_wrap_c", 32'(flags[1]), 32'd1);
        applyStimulus(3'd7, 8'h05, 8'h00, 1'b1, "acc_clr_acc");
        checkOutput("acc_clr_acc_const", 32'(result), 32'h0005);

        // Enable low mid-multiply: everything freezes, acc_clr ignored, then resumes.
        opcode = 3'd6; a = 8'h9C; b = 8'h37; in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 3; i++) begin step(); lat++; end
        en = 1'b0;
        acc_clr = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("en_low_in_ready", 32'(in_ready), 32'd0);
            checkOutput("en_low_out_valid", 32'(out_valid), 32'd0);
            checkOutput("en_low_busy", 32'(busy), 32'd1);
            step();
            lat++;
        end
        en = 1'b1;
        acc_clr = 1'b0;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin step(); lat++; end
        expv = refModel(6, 8'h9C, 8'h37, modelAcc, dummy);
        checkOutput("en_mul_latency", 32'(lat), 32'd14);
        checkOutput("en_mul_result", 32'(result), 32'(expv[15:0]));
        applyStimulus(3'd7, 8'h01, 8'h00, 1'b0, "acc_after_en");

        // Randomized operations against the model.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                          ($urandom_range(0, 9) == 0), "rand");
        end

        // Asynchronous reset in the middle of a multiply.
        step();
        opcode = 3'd6; a = 8'hAB; b = 8'hCD; in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_result", 32'(result), 32'd0);
        checkOutput("midrst_flags", 32'(flags), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        modelAcc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3'd0, 8'h12, 8'h34, 1'b0, "post_rst_add");
        applyStimulus(3'd7, 8'h07, 8'h00, 1'b0, "post_rst_acc");
        checkOutput("post_rst_acc_const", 32'(result), 32'h0007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
